// File: rtl/fir_audio_pkg.sv
// Shared constants and the rounding helper for the FIR audio output path.
// Widths default to a 31-bit filter result rescaled to 16-bit audio.
package fir_audio_pkg;

    localparam int IN_W_DEF  = 31;
    localparam int OUT_W_DEF = 16;
    localparam int SHIFT_DEF = 15;

    // Internal arithmetic width; wide enough for any IN_W up to 63.
    localparam int CALC_W = 64;

    localparam logic [15:0] SAT_MAX = 16'h7FFF;
    localparam logic [15:0] SAT_MIN = 16'h8000;

    // Round half up, then arithmetic shift right.
    function automatic logic signed [CALC_W-1:0] round_shift(
        input logic signed [CALC_W-1:0] x,
        input int unsigned              shift
    );
        logic signed [CALC_W-1:0] bias;
        bias = 64'sd1 <<< (shift - 1);
        return (x + bias) >>> shift;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO with an occupancy output.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module sync_fifo_fwft #(
    parameter int DW    = 16,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          ready_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    output logic [AW:0]   level_o,
    output logic          drop_o
);

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_cnt_q, wr_cnt_d;
    logic [AW:0]   rd_cnt_q, rd_cnt_d;
    logic [AW:0]   level;
    logic          empty, full, pop, push_ok;

    assign level   = wr_cnt_q - rd_cnt_q;
    assign empty   = (level == '0);
    assign full    = (level == FULL_LVL);
    assign pop     = ~empty & ready_i;
    assign push_ok = push_i & (~full | pop);

    assign valid_o = ~empty;
    assign level_o = level;
    assign data_o  = empty ? '0 : mem[rd_cnt_q[AW-1:0]];
    assign drop_o  = push_i & ~push_ok & ~flush_i;

    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        if (flush_i) begin
            wr_cnt_d = '0;
            rd_cnt_d = '0;
        end else begin
            if (push_ok) wr_cnt_d = wr_cnt_q + (AW+1)'(1);
            if (pop)     rd_cnt_d = rd_cnt_q + (AW+1)'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    // NOTE: storage has no reset; the counters alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push_ok && !flush_i) mem[wr_cnt_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/fir_out_sink.sv
// FIR output sink: rounds, shifts and saturates each result to audio width,
// then buffers it in a FWFT FIFO behind a valid/ready handshake.
module fir_out_sink
    import fir_audio_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int SHIFT = SHIFT_DEF,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    flush,
    input  logic                    valid,
    input  logic signed [IN_W-1:0]  yout,
    output logic                    dout_valid,
    output logic [OUT_W-1:0]        dout,
    input  logic                    dout_ready,
    output logic [AW:0]             level,
    output logic [15:0]             sat_cnt,
    output logic [15:0]             drop_cnt,
    output logic                    overflow
);

    localparam logic signed [CALC_W-1:0] Q_MAX = (64'sd1 <<< (OUT_W - 1)) - 64'sd1;
    localparam logic signed [CALC_W-1:0] Q_MIN = -(64'sd1 <<< (OUT_W - 1));

    logic signed [CALC_W-1:0] yout_ext, q_wide;
    logic [OUT_W-1:0]         sample;
    logic                     clamp;

    logic             stage_vld_q, stage_vld_d;
    logic [OUT_W-1:0] stage_data_q, stage_data_d;
    logic [15:0]      sat_cnt_q, sat_cnt_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d;
    logic             ovf_q, ovf_d;
    logic             fifo_drop;

    assign yout_ext = CALC_W'(yout);
    assign q_wide   = round_shift(yout_ext, SHIFT);

    always_comb begin
        sample = q_wide[OUT_W-1:0];
        clamp  = 1'b0;
        if (q_wide > Q_MAX) begin
            sample = OUT_W'(SAT_MAX);
            clamp  = 1'b1;
        end else if (q_wide < Q_MIN) begin
            sample = OUT_W'(SAT_MIN);
            clamp  = 1'b1;
        end
    end

    // A sample arriving with flush is discarded outright, so it is not counted either.
    always_comb begin
        stage_vld_d  = valid & ~flush;
        stage_data_d = valid ? sample : stage_data_q;
        sat_cnt_d    = sat_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        ovf_d        = ovf_q | fifo_drop;
        if (valid && !flush && clamp && sat_cnt_q != 16'hFFFF)
            sat_cnt_d = sat_cnt_q + 16'd1;
        if (fifo_drop && drop_cnt_q != 16'hFFFF)
            drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stage_vld_q  <= 1'b0;
            stage_data_q <= '0;
            sat_cnt_q    <= '0;
            drop_cnt_q   <= '0;
            ovf_q        <= 1'b0;
        end else begin
            stage_vld_q  <= stage_vld_d;
            stage_data_q <= stage_data_d;
            sat_cnt_q    <= sat_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            ovf_q        <= ovf_d;
        end
    end

    sync_fifo_fwft #(
        .DW    (OUT_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk         (clk),
        .rstn        (rstn),
        .flush_i     (flush),
        .push_i      (stage_vld_q),
        .push_data_i (stage_data_q),
        .ready_i     (dout_ready),
        .valid_o     (dout_valid),
        .data_o      (dout),
        .level_o     (level),
        .drop_o      (fifo_drop)
    );

    assign sat_cnt  = sat_cnt_q;
    assign drop_cnt = drop_cnt_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_fir_out_sink.sv
// Self-checking bench for fir_out_sink: rescale vector table, a scoreboard
// model of the stage/FIFO, and hand-written overflow, flush and reset sequences.
module tb_fir_out_sink;

    localparam int IN_W  = 31;
    localparam int OUT_W = 16;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             flush = 1'b0;
    logic             valid = 1'b0;
    logic [IN_W-1:0]  yout = '0;
    logic             dout_ready = 1'b0;
    logic             dout_valid;
    logic [OUT_W-1:0] dout;
    logic [AW:0]      level;
    logic [15:0]      sat_cnt;
    logic [15:0]      drop_cnt;
    logic             overflow;

    fir_out_sink #(
        .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(15), .DEPTH(DEPTH), .AW(AW)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .flush      (flush),
        .valid      (valid),
        .yout       (yout),
        .dout_valid (dout_valid),
        .dout       (dout),
        .dout_ready (dout_ready),
        .level      (level),
        .sat_cnt    (sat_cnt),
        .drop_cnt   (drop_cnt),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [15:0] sb[$];
    bit          st_v;
    logic [15:0] st_s;
    int          m_sat, m_drop;
    bit          m_ovf;

    typedef struct {
        logic [IN_W-1:0] y;
        logic [15:0]     exp_s;
        bit              exp_sat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [16:0] ref_rescale(input logic [IN_W-1:0] y);
        longint v, q;
        v = longint'($signed(y));
        q = (v + 64'sd16384) >>> 15;
        if (q > 32767)  return {1'b1, 16'h7FFF};
        if (q < -32768) return {1'b1, 16'h8000};
        return {1'b0, q[15:0]};
    endfunction

    task automatic model_reset();
        sb.delete();
        st_v   = 1'b0;
        st_s   = '0;
        m_sat  = 0;
        m_drop = 0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_step(input bit v, input logic [IN_W-1:0] y, input bit rdy, input bit fl);
        logic [16:0] r;
        bit          was_full, pop;
        if (fl) begin
            sb.delete();
            st_v = 1'b0;
        end else begin
            was_full = (sb.size() == DEPTH);
            pop      = (sb.size() > 0) && rdy;
            if (pop) void'(sb.pop_front());
            if (st_v) begin
                if (!was_full || pop) sb.push_back(st_s);
                else begin
                    if (m_drop < 16'hFFFF) m_drop++;
                    m_ovf = 1'b1;
                end
            end
            r    = ref_rescale(y);
            st_v = v;
            if (v) begin
                st_s = r[15:0];
                if (r[16] && m_sat < 16'hFFFF) m_sat++;
            end
        end
    endtask

    task automatic check_all();
        check("level", 32'(level), 32'(sb.size()));
        check("dout_valid", 32'(dout_valid), 32'(sb.size() > 0));
        check("dout", 32'(dout), (sb.size() > 0) ? 32'(sb[0]) : 32'd0);
        check("sat_cnt", 32'(sat_cnt), 32'(m_sat));
        check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        check("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_dout_valid"}, 32'(dout_valid), 32'd0);
        check({tag, "_dout"}, 32'(dout), 32'd0);
        check({tag, "_level"}, 32'(level), 32'd0);
        check({tag, "_sat_cnt"}, 32'(sat_cnt), 32'd0);
        check({tag, "_drop_cnt"}, 32'(drop_cnt), 32'd0);
        check({tag, "_overflow"}, 32'(overflow), 32'd0);
    endtask

    // Drive at the falling edge, model the rising edge, check at the next falling edge.
    task automatic cyc(input bit v, input logic [IN_W-1:0] y, input bit rdy, input bit fl);
        valid      = v;
        yout       = y;
        dout_ready = rdy;
        flush      = fl;
        @(posedge clk);
        model_step(v, y, rdy, fl);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        vec_t vecs[10];
        int   exp_sat_sum;

        vecs[0] = '{31'h0000_4000, 16'h0001, 1'b0};
        vecs[1] = '{31'h0000_3FFF, 16'h0000, 1'b0};
        vecs[2] = '{31'h7FFF_C000, 16'h0000, 1'b0};
        vecs[3] = '{31'h7FFF_BFFF, 16'hFFFF, 1'b0};
        vecs[4] = '{31'h3FFF_FFFF, 16'h7FFF, 1'b1};
        vecs[5] = '{31'h4000_0000, 16'h8000, 1'b0};
        vecs[6] = '{31'h3FFF_BFFF, 16'h7FFF, 1'b0};
        vecs[7] = '{31'h3FFF_C000, 16'h7FFF, 1'b1};
        vecs[8] = '{31'h0001_86A0, 16'h0003, 1'b0};
        vecs[9] = '{31'h7FFE_7960, 16'hFFFD, 1'b0};

        model_reset();
        repeat (2) @(negedge clk);
        check_zero("reset");
        rstn = 1'b1;

        // First-sample latency: visible after the second edge, drained on the third.
        cyc(1'b1, 31'h0000_4000, 1'b1, 1'b0);
        check("lat_edge1_valid", 32'(dout_valid), 32'd0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("lat_edge2_valid", 32'(dout_valid), 32'd1);
        check("lat_edge2_dout", 32'(dout), 32'h0001);
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("lat_edge3_level", 32'(level), 32'd0);

        // Rescale table
        exp_sat_sum = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, vecs[i].y, 1'b1, 1'b0);
            cyc(1'b0, '0, 1'b1, 1'b0);
            check($sformatf("vec%0d_valid", i), 32'(dout_valid), 32'd1);
            check($sformatf("vec%0d_dout", i), 32'(dout), 32'(vecs[i].exp_s));
            exp_sat_sum += int'(vecs[i].exp_sat);
            cyc(1'b0, '0, 1'b1, 1'b0);
        end
        check("tbl_sat_cnt", 32'(sat_cnt), 32'(exp_sat_sum));

        // Overflow: 20 samples into a stalled FIFO
        for (int i = 0; i < 20; i++) cyc(1'b1, IN_W'((i + 1) * 32768), 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        check("ovf_level", 32'(level), 32'd16);
        check("ovf_drop_cnt", 32'(drop_cnt), 32'd4);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_head", 32'(dout), 32'h0001);

        // Full FIFO with push and pop on the same edge
        cyc(1'b1, IN_W'(100 * 32768), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, IN_W'((101 + i) * 32768), 1'b1, 1'b0);
            check($sformatf("full_pp%0d_level", i), 32'(level), 32'd16);
            check($sformatf("full_pp%0d_drop", i), 32'(drop_cnt), 32'd4);
        end
        for (int i = 0; i < 20; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        check("drain_level", 32'(level), 32'd0);

        // Flush at level 5 together with a new sample
        for (int i = 0; i < 5; i++) cyc(1'b1, IN_W'((200 + i) * 32768), 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        check("pre_flush_level", 32'(level), 32'd5);
        cyc(1'b1, IN_W'(300 * 32768), 1'b0, 1'b1);
        check("flush_level", 32'(level), 32'd0);
        check("flush_valid", 32'(dout_valid), 32'd0);
        check("flush_drop", 32'(drop_cnt), 32'd4);
        cyc(1'b0, '0, 1'b0, 1'b0);
        check("post_flush_level", 32'(level), 32'd0);

        // Asynchronous reset mid-burst, checked before the next rising edge
        for (int i = 0; i < 6; i++) cyc(1'b1, IN_W'((400 + i) * 32768), 1'b0, 1'b0);
        #2 rstn = 1'b0;
        #1 check_zero("async_rst");
        model_reset();
        @(negedge clk);
        valid      = 1'b0;
        dout_ready = 1'b0;
        rstn       = 1'b1;
        check_all();
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("post_rst_level", 32'(level), 32'd0);

        // Traffic resumes normally after reset
        cyc(1'b1, 31'h0000_C000, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("post_rst_dout", 32'(dout), 32'h0002);
        cyc(1'b0, '0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fir_out_sink.md
Name: fir_out_sink

Overview:
Consumer end of the FIR filter output interface. It accepts the filter's one-cycle `valid` strobe with the wide signed `yout` result and rescales it to 16-bit audio by round-half-up, arithmetic shift and saturation. Rescaled samples are buffered in a small FIFO and presented to downstream logic (FFT front end or audio TX) over a valid/ready handshake. It turns the free-running, unthrottled filter output into a back-pressurable stream, and it flags any sample lost to overflow.

Parameters:
IN_W, 31, width of signed FIR result `yout`
OUT_W, 16, width of signed output sample
SHIFT, 15, right-shift applied after rounding (coefficient Q-format); must satisfy 1 <= SHIFT < IN_W
DEPTH, 16, FIFO entries; power of two, >= 4
AW, 4, log2(DEPTH)

Ports:
clk  input  1  system clock; all logic on rising edge
rstn  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of FIFO and stage register; does not clear counters
valid  input  1  FIR result strobe, one cycle per sample, no back-pressure
yout  input  IN_W  signed FIR result, sampled when valid=1
dout_valid  output  1  FIFO non-empty
dout  output  OUT_W  signed sample at FIFO head (first-word-fall-through)
dout_ready  input  1  downstream accept
level  output  AW+1  current FIFO occupancy, 0..DEPTH
sat_cnt  output  16  count of saturated samples, sticks at 0xFFFF
drop_cnt  output  16  count of samples dropped on full, sticks at 0xFFFF
overflow  output  1  sticky, set on first drop

Behaviour:
- Reset (rstn=0, async): dout_valid=0, dout=0, level=0, sat_cnt=0, drop_cnt=0, overflow=0, pointers=0, stage register invalid.
- Stage 1 (rescale, registered): when valid=1 at edge N:
  - sum = sign-extend(yout) to IN_W+1 bits, plus 2^(SHIFT-1).
  - q = sum >>> SHIFT (arithmetic shift).
  - If q > 2^(OUT_W-1)-1, s = 0x7FFF. If q < -2^(OUT_W-1), s = 0x8000. Otherwise s = q[OUT_W-1:0].
  - s and stage-valid are registered at edge N. sat_cnt increments at edge N when clamping occurred.
- Stage 2 (FIFO write): stage-valid at edge N+1 writes s.
  - Write is accepted if level < DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the sample is dropped: drop_cnt increments and overflow is set.
- Latency: valid at edge N gives dout_valid=1 after edge N+1 when the FIFO was empty (2 cycles). Back-to-back valid gives 1 sample per clock.
- Read: dout = mem[rd_ptr], combinational from memory, and dout is 0 when empty. A pop occurs on a rising edge with dout_valid & dout_ready; rd_ptr increments.
- dout_ready while empty has no effect.
- Pointers wrap modulo DEPTH. level = wr_count - rd_count.
- Simultaneous push and pop:
  - At 0 < level < DEPTH, level is unchanged.
  - At level = DEPTH, the push is accepted and level stays DEPTH.
  - At level = 0, only the push takes effect; no pop occurs and dout_valid rises next cycle.
- flush=1 at an edge: pointers and level go to 0 and the stage register is invalidated. A valid arriving in the same cycle is discarded and not counted as a drop. Counters and overflow hold.
- Reset mid-stream: everything clears immediately, whether in stage, in FIFO or in flight.
- Counters saturate at 0xFFFF; they never wrap.

Decomposition:
- Shared package `fir_audio_pkg`: IN_W/OUT_W/SHIFT defaults, saturation limit constants `SAT_MAX=16'h7FFF` and `SAT_MIN=16'h8000`, and the rounding helper function.
- One sub-module, `sync_fifo_fwft` (params DW, DEPTH, AW), handles storage, pointers, level and push/pop-at-full rules.
- The top level holds the rescale stage, counters and overflow flag.

Test Plan:
- Reset, then valid=1 with yout=0x0000_4000, dout_ready=1 -> dout_valid rises 2 cycles later, dout=0x0001, level returns to 0 the next cycle.
- Rounding: yout=0x0000_3FFF -> 0x0000. yout = -16384 (0x7FFF_C000 in 31 bits) -> 0x0000. yout = -16385 -> 0xFFFF. sat_cnt stays 0.
- Saturation: yout=0x3FFF_FFFF -> 0x7FFF. yout=0x4000_0000 (-2^30) -> 0x8000 with no clamp. sat_cnt=1 after both.
- Overflow: dout_ready=0 and 20 consecutive valids -> level=16, drop_cnt=4, overflow=1. Then dout_ready=1 -> first 16 samples drain in order.
- Full with simultaneous push/pop: with level=16, valid every cycle and dout_ready=1 -> level holds 16 and drop_cnt stays unchanged.
- flush with level=5, asserted in the same cycle as valid -> level=0 next cycle, dout_valid=0, drop_cnt unchanged. Async rstn pulse mid-burst clears all outputs within the same cycle.
